// File: rtl/audio_pkg.sv
// Shared audio definitions: sample/magnitude widths, reader FSM states and
// the saturating absolute-value helper used by audio datapath blocks.
package audio_pkg;

  localparam int SAMPLE_W = 32;
  localparam int MAG_W    = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EVAL = 2'd2
  } state_t;

  // The most negative sample has no positive twin, so clamp it to full scale.
  function automatic logic [MAG_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] neg;
    neg = ~x + SAMPLE_W'(1);
    if (!x[SAMPLE_W-1])
      return x[MAG_W-1:0];
    else if (x == {1'b1, {MAG_W{1'b0}}})
      return {MAG_W{1'b1}};
    else
      return neg[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/audio_clap_detector_peak_meter.sv
// Windowed peak meter: tracks the largest magnitude over WINDOW samples and
// publishes its top 8 bits when each window closes.
module peak_meter
  import audio_pkg::*;
#(
  parameter int WINDOW = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [MAG_W-1:0] mag,
  output logic [7:0]       level
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic [MAG_W-1:0] peak_reg;
  logic [MAG_W-1:0] peak_next;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [7:0]       level_reg;

  assign peak_next = (mag > peak_reg) ? mag : peak_reg;
  assign level     = level_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      peak_reg    <= '0;
      win_cnt_reg <= '0;
      level_reg   <= '0;
    end else if (sample_valid) begin
      if (win_cnt_reg == WIN_LAST) begin
        // The closing sample counts toward the window it ends.
        level_reg   <= peak_next[MAG_W-1 -: 8];
        peak_reg    <= '0;
        win_cnt_reg <= '0;
      end else begin
        peak_reg    <= peak_next;
        win_cnt_reg <= win_cnt_reg + WIN_W'(1);
      end
    end
  end

endmodule

// File: rtl/audio_clap_detector.sv
// Audio-input clap detector: drains L/R pairs from the codec input FIFO,
// fires a one-cycle strobe on loud samples with hold-off and hysteresis.
module audio_clap_detector
  import audio_pkg::*;
#(
  parameter logic [MAG_W-1:0] THRESHOLD = 31'h1000_0000,
  parameter int               HOLDOFF   = 4800,
  parameter int               WINDOW    = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                audio_in_available,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  output logic                read_audio_in,
  output logic                clap_pulse,
  output logic [7:0]          level,
  output logic                armed
);

  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [MAG_W-1:0] REARM_LEVEL = THRESHOLD >> 1;

  state_t              state_reg;
  state_t              state_next;
  logic [SAMPLE_W-1:0] left_reg;
  logic [SAMPLE_W-1:0] right_reg;
  logic                read_reg;
  logic                clap_reg;
  logic                armed_reg;
  logic [HOLD_W-1:0]   holdoff_reg;

  logic [MAG_W-1:0]    mag_left;
  logic [MAG_W-1:0]    mag_right;
  logic [MAG_W-1:0]    mag;
  logic                eval;
  logic                fire;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (audio_in_available) state_next = READ;
      READ:    state_next = EVAL;
      EVAL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mag_left  = sat_abs(left_reg);
  assign mag_right = sat_abs(right_reg);
  assign mag       = (mag_left > mag_right) ? mag_left : mag_right;
  assign eval      = (state_reg == EVAL);
  assign fire      = eval && armed_reg && enable && (mag >= THRESHOLD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      left_reg    <= '0;
      right_reg   <= '0;
      read_reg    <= 1'b0;
      clap_reg    <= 1'b0;
      armed_reg   <= 1'b1;
      holdoff_reg <= '0;
    end else begin
      state_reg <= state_next;
      // read strobe is registered so it coincides exactly with the READ state
      read_reg  <= (state_next == READ);
      clap_reg  <= fire;
      if (state_reg == READ) begin
        left_reg  <= left_in;
        right_reg <= right_in;
      end
      if (fire) begin
        armed_reg   <= 1'b0;
        holdoff_reg <= HOLD_W'(HOLDOFF);
      end else if (eval && !armed_reg) begin
        if (holdoff_reg != '0)
          holdoff_reg <= holdoff_reg - HOLD_W'(1);
        else if (mag < REARM_LEVEL)
          armed_reg <= 1'b1;
      end
    end
  end

  assign read_audio_in = read_reg;
  assign clap_pulse    = clap_reg;
  assign armed         = armed_reg;

  peak_meter #(
    .WINDOW(WINDOW)
  ) u_peak_meter (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(eval),
    .mag         (mag),
    .level       (level)
  );

endmodule

// File: doc/audio_clap_detector.md
# audio_clap_detector

Audio-input reader for the trading board. It drains ADC samples from the input side of `audio_controller` (`audio_in_available` / `read_audio_in`), which is the opposite direction to the tone generator that writes DAC samples. It computes a per-sample magnitude and raises a one-cycle `clap_pulse` when the level crosses a threshold, with hold-off and hysteresis. A windowed peak meter `level` feeds the VGA display.

## Interface
Parameters:
- `THRESHOLD`, default 31'h1000_0000: magnitude at or above which a clap fires.
- `HOLDOFF`, default 4800: samples after a clap during which no new clap fires (100 ms at 48 kHz).
- `WINDOW`, default 1024: samples per peak-meter window. Must be ≥1.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  when 0, samples are still drained but `clap_pulse` is suppressed.
- `audio_in_available`  in  1  input FIFO holds at least one L/R pair.
- `left_in`  in  32  signed left sample, valid while `audio_in_available`=1.
- `right_in`  in  32  signed right sample, same validity as `left_in`.
- `read_audio_in`  out  1  pops one sample pair on the rising edge where it is 1.
- `clap_pulse`  out  1  one-cycle detection strobe.
- `level`  out  8  peak magnitude of the last complete window, bits [30:23].
- `armed`  out  1  1 when the detector can fire.

## Operation
- FSM states:
  - IDLE:
    - `read_audio_in`=0.
    - If `audio_in_available`=1, go to READ.
  - READ:
    - `read_audio_in`=1 for exactly this cycle.
    - Register `left_in`/`right_in` on this edge.
    - Go to EVAL.
  - EVAL:
    - Compute the magnitude.
    - Update the detector, hold-off, peak and window.
    - Go to IDLE.
- Magnitude:
  - `sat_abs(x)` = x≥0 ? x[30:0] : (−x)[30:0].
  - x = 32'h8000_0000 saturates to 31'h7FFF_FFFF.
  - mag = max(sat_abs(L), sat_abs(R)), 31 bits, unsigned.
- Detector, evaluated in EVAL:
  - If `armed` and mag ≥ THRESHOLD and `enable`:
    - `clap_pulse` asserts next cycle.
    - `armed` goes to 0.
    - `holdoff_cnt` loads HOLDOFF.
  - If not `armed` and `holdoff_cnt`≠0:
    - `holdoff_cnt` decrements.
  - If not `armed` and `holdoff_cnt`=0 and mag < (THRESHOLD>>1):
    - `armed` goes to 1 (hysteresis re-arm).
  - Otherwise hold.
- Suppression by `enable`=0:
  - A crossing neither fires nor disarms.
  - An in-progress hold-off continues counting.
- Peak meter, evaluated in EVAL:
  - `peak` = max(`peak`, mag).
  - `win_cnt` increments.
  - When `win_cnt`=WINDOW−1:
    - `level` ← max(`peak`, mag)[30:23].
    - `peak` ← 0.
    - `win_cnt` ← 0.
- Reset values:
  - `read_audio_in`=0, `clap_pulse`=0, `level`=0, `armed`=1.
  - FSM=IDLE, `peak`=0, `win_cnt`=0, `holdoff_cnt`=0.
- Reset mid-operation:
  - Reset asserted during READ still lets that pop complete (the controller sees the edge), but the captured sample is discarded.
  - Reset during EVAL discards the sample with no clap.
- The FIFO is never popped when `audio_in_available`=0. The FSM never leaves IDLE without it.

## Timing
- `audio_in_available` seen high in IDLE at cycle n:
  - `read_audio_in` high in cycle n+1.
  - EVAL in n+2.
  - `clap_pulse` and `level` update visible in n+3.
- Sustained throughput: one sample per 3 cycles. This is far above 48 kHz, so the FIFO never fills.
- `clap_pulse` lasts exactly 1 cycle. Consecutive claps are at least HOLDOFF+1 samples apart.
- `armed` changes one cycle after the EVAL that decides it.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package `audio_pkg`:
  - State enum {IDLE, READ, EVAL}.
  - `SAMPLE_W`=32 and `MAG_W`=31.
  - `sat_abs` function.
  - This lets `my_tone` and future audio blocks share the widths.
- One sub-module, `peak_meter`, holding the `peak`/`win_cnt`/`level` registers.
  - Input: mag plus a one-cycle `sample_valid` (EVAL).
  - Parameter: WINDOW.
- The FSM, the detector and `holdoff_cnt` live in the top of the block.

## Test plan
- Reset, then one sample L=32'h2000_0000, R=0, with `available` high at cycle n:
  - `read_audio_in` is high only at n+1.
  - `clap_pulse` is high only at n+3.
  - `armed`=0 from n+3.
- L=32'h8000_0000 with THRESHOLD=31'h7FFF_FFFF:
  - mag saturates to 31'h7FFF_FFFF.
  - The clap fires.
  - No overflow to 0.
- HOLDOFF=4, stream 20 samples all at 32'h3000_0000:
  - Exactly one clap.
  - `armed` stays 0 because the hysteresis level is never met.
  - Then one sample at 0 re-arms, and the next loud sample fires the second clap.
- WINDOW=4, magnitudes 5, 9, 2, 32'h0100_0000:
  - `level`=8'h02 after the 4th EVAL.
  - The next window of zeros gives `level`=0.
- `enable`=0 with a loud sample:
  - Sample popped.
  - No `clap_pulse`.
  - `armed` stays 1.
- Reset asserted the cycle `read_audio_in` is high:
  - No clap.
  - FSM in IDLE next cycle.
  - `level`=0.
